// File: rtl/sign_packer_if.sv
// sign_packer_if: start/snapshot inputs, status outputs and the valid/ready word stream of sign_packer.
interface sign_packer_if #(
  parameter int DIM = 1024,
  parameter int OUT_W = 32
);
  logic start;
  logic [DIM-1:0] sign_bits;
  logic busy;
  logic done;
  logic [OUT_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport master (
    input  start, sign_bits, m_ready,
    output busy, done, m_data, m_valid, m_last
  );
  modport slave (
    output start, sign_bits, m_ready,
    input  busy, done, m_data, m_valid, m_last
  );
endinterface

// File: rtl/sign_packer.sv
// sign_packer: snapshots DIM sign bits on start and streams them as OUT_W-bit words (dimension 0 first).
// Define SIGN_PACK_PARITY_EN to append an XOR parity word after the data words.
module sign_packer #(
  parameter int DIM = 1024,
  parameter int OUT_W = 32
) (
  input logic clk,
  input logic rst,
  sign_packer_if.master pk
);
  localparam int WORDS = DIM / OUT_W;
`ifdef SIGN_PACK_PARITY_EN
  localparam int NW = WORDS + 1;
`else
  localparam int NW = WORDS;
`endif
  localparam int IW = $clog2(WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q;
  logic [DIM-1:0] snap_q;
  logic [IW-1:0] idx_q, nxt_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic valid_q, last_q, busy_q, done_q, xfer;
`ifdef SIGN_PACK_PARITY_EN
  logic [OUT_W-1:0] par_q;
`endif
  assign xfer = valid_q && pk.m_ready;
  always_comb begin
    nxt_d = idx_q + 1'b1;
`ifdef SIGN_PACK_PARITY_EN
    data_d = (nxt_d == IW'(WORDS)) ? par_q ^ data_q : snap_q[OUT_W*int'(nxt_d) +: OUT_W];
`else
    data_d = snap_q[OUT_W*int'(nxt_d) +: OUT_W];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SIGN_PACK_PARITY_EN
      par_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (pk.start) begin
          state_q <= SEND;
          snap_q <= pk.sign_bits;
          idx_q <= '0;
          data_q <= pk.sign_bits[OUT_W-1:0];
          valid_q <= 1'b1;
          last_q <= (NW == 1);
          busy_q <= 1'b1;
`ifdef SIGN_PACK_PARITY_EN
          par_q <= '0;
`endif
        end
        SEND: if (xfer) begin
`ifdef SIGN_PACK_PARITY_EN
          par_q <= par_q ^ data_q;
`endif
          if (idx_q == LAST) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx_q <= nxt_d;
            data_q <= data_d;
            last_q <= (nxt_d == LAST);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pk.m_data = data_q;
  assign pk.m_valid = valid_q;
  assign pk.m_last = last_q;
  assign pk.busy = busy_q;
  assign pk.done = done_q;
endmodule

// File: tb/tb_sign_packer.sv
// tb_sign_packer: directed vector table plus backpressure, restart, reset and counter-bank sequences.
module tb_sign_packer;
  localparam int DIM = 64;
  localparam int OUT_W = 32;
`ifdef SIGN_PACK_PARITY_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif
  typedef struct {
    logic [63:0] sb;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sign_packer_if #(.DIM(DIM), .OUT_W(OUT_W)) pk();
  sign_packer #(.DIM(DIM), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .pk(pk));
  int tests = 0;
  int fails = 0;
  vec_t vecs[5];
  logic [31:0] got[$];
  int dones;
  int cnt[DIM];
  logic st_a, st_b, bank_st;
  logic [63:0] en_a, en_b, neg_a, neg_b, bank_en, bank_neg, bank_sign;
  always @(posedge clk) begin
    st_a <= bank_st;
    en_a <= bank_en;
    neg_a <= bank_neg;
    st_b <= st_a;
    en_b <= en_a;
    neg_b <= neg_a;
    if (st_b) for (int d = 0; d < DIM; d++) if (en_b[d]) cnt[d] <= cnt[d] + (neg_b[d] ? -1 : 1);
  end
  always_comb begin
    bank_sign = '0;
    for (int d = 0; d < DIM; d++) bank_sign[d] = cnt[d] < 0;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input logic [63:0] sb);
    pk.sign_bits = sb;
    pk.start = 1'b1;
    step;
    pk.start = 1'b0;
  endtask
  task automatic run_stream(input vec_t v);
    pk.m_ready = 1'b1;
    kick(v.sb);
    chk("w0_valid", pk.m_valid, 1);
    chk("w0_data", pk.m_data, v.w0);
    chk("w0_last", pk.m_last, 0);
    chk("w0_busy", pk.busy, 1);
    step;
    chk("w1_data", pk.m_data, v.w1);
    chk("w1_last", pk.m_last, NW == 2);
`ifdef SIGN_PACK_PARITY_EN
    step;
    chk("par_data", pk.m_data, v.p);
    chk("par_last", pk.m_last, 1);
`endif
    step;
    chk("done_pulse", pk.done, 1);
    chk("done_valid", pk.m_valid, 0);
    chk("done_busy", pk.busy, 1);
    step;
    chk("idle_done", pk.done, 0);
    chk("idle_busy", pk.busy, 0);
  endtask
  // mode 0: ready held high; mode 1: stalled 5 cycles then toggling. A start pulse with all-ones bits is injected at cycle hit.
  task automatic collect(input int mode, input int hit, input int budget);
    got.delete();
    dones = 0;
    for (int c = 0; c < budget; c++) begin
      pk.m_ready = (mode == 0) || (c >= 5 && c % 2 == 1);
      if (mode == 1 && c < 5) chk("stall_data", pk.m_data, 64'h01234567);
      if (pk.m_valid && pk.m_ready) got.push_back(pk.m_data);
      if (pk.done) dones++;
      pk.start = (c == hit);
      if (c == hit) pk.sign_bits = '1;
      step;
    end
    pk.start = 1'b0;
  endtask
  task automatic check_got(input string tag, input vec_t v);
    logic [31:0] exp[3];
    exp = '{v.w0, v.w1, v.p};
    chk({tag, "_words"}, got.size(), NW);
    chk({tag, "_dones"}, dones, 1);
    for (int i = 0; i < got.size() && i < NW; i++) chk({tag, "_word"}, got[i], exp[i]);
    chk({tag, "_busy"}, pk.busy, 0);
  endtask
  task automatic store(input logic [63:0] en, input logic [63:0] neg);
    bank_en = en;
    bank_neg = neg;
    bank_st = 1'b1;
    step;
    bank_st = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    vec_t bv;
    vecs[0] = '{64'hDEADBEEF_01234567, 32'h01234567, 32'hDEADBEEF, 32'hDF8EFB88};
    vecs[1] = '{64'h0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    vecs[3] = '{64'h80000000_00000001, 32'h00000001, 32'h80000000, 32'h80000001};
    vecs[4] = '{64'hFFFF0000_0F0F0F0F, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F};
    pk.start = 1'b0;
    pk.sign_bits = '0;
    pk.m_ready = 1'b0;
    bank_st = 1'b0;
    bank_en = '0;
    bank_neg = '0;
    step;
    step;
    chk("rst_valid", pk.m_valid, 0);
    chk("rst_busy", pk.busy, 0);
    chk("rst_done", pk.done, 0);
    chk("rst_last", pk.m_last, 0);
    chk("rst_data", pk.m_data, 0);
    rst = 1'b0;
    step;
    for (int i = 0; i < 5; i++) run_stream(vecs[i]);
    pk.m_ready = 1'b0;
    kick(vecs[0].sb);
    collect(1, -1, 20);
    check_got("bp", vecs[0]);
    kick(vecs[0].sb);
    collect(0, 0, 12);
    check_got("iso", vecs[0]);
    kick(vecs[0].sb);
    collect(0, NW, 12);
    check_got("dstart", vecs[0]);
    pk.m_ready = 1'b0;
    kick(vecs[0].sb);
    step;
    chk("pre_rst_valid", pk.m_valid, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_valid", pk.m_valid, 0);
    chk("mid_rst_busy", pk.busy, 0);
    chk("mid_rst_last", pk.m_last, 0);
    chk("mid_rst_data", pk.m_data, 0);
    for (int c = 0; c < 5; c++) begin
      chk("mid_rst_nodone", pk.done, 0);
      step;
    end
    run_stream(vecs[0]);
    store('1, '0);
    store('1, '0);
    for (int k = 0; k < 5; k++) store(64'h20, 64'h20);
    step;
    step;
    bv = '{bank_sign, 32'h00000020, 32'h00000000, 32'h00000020};
    run_stream(bv);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
